slinky_ram_ctrl: RTL and testbench



---
 rtl/slinky_pkg.sv | 28 ++
 rtl/slinky_ram_ctrl_if.sv | 30 +++
 rtl/slinky_refresh_timer.sv | 25 ++
 rtl/slinky_ram_ctrl.sv | 151 +++++++++++++++
 tb/tb_slinky_ram_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/slinky_pkg.sv
// Shared constants for the slinky RAM controller: register offsets, Cfg bits
// and the eight bus-sequencer states.
package slinky_pkg;

    localparam logic [3:0] REG_ADDRL = 4'h0;
    localparam logic [3:0] REG_ADDRM = 4'h1;
    localparam logic [3:0] REG_ADDRH = 4'h2;
    localparam logic [3:0] REG_DATA  = 4'h3;
    localparam logic [3:0] REG_CFG   = 4'hE;
    localparam logic [3:0] REG_BANK  = 4'hF;

    localparam int CFG_DEC   = 0;
    localparam int CFG_INCEN = 1;
    localparam logic [7:0] CFG_RESET = 8'h02;

    // 1..3 carry the refresh slot, 4..6 the data access; 0 and 7 are waits.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REF_CAS = 3'd1,
        S_REF_RAS = 3'd2,
        S_REF_END = 3'd3,
        S_ROW     = 3'd4,
        S_COL     = 3'd5,
        S_COL2    = 3'd6,
        S_HOLD    = 3'd7
    } seq_state_t;

endpackage

// File: rtl/slinky_ram_ctrl_if.sv
// Slot-bus and DRAM-side signal bundle of the slinky RAM controller.
interface slinky_ram_ctrl_if #(
    parameter int RA_W  = 11,
    parameter int BANKS = 2
);
    // Slot side qualifies every transfer with nDEVSEL low; there is no
    // back-pressure, the controller completes within one PHI cycle.
    logic             nDEVSEL;
    logic             nWE;
    logic [3:0]       A;
    logic [7:0]       Din;
    logic [7:0]       Dout;
    logic             RegOE;
    logic             RamSel;
    logic [RA_W-1:0]  RA;
    logic             nRAS;
    logic [BANKS-1:0] nCAS;
    logic             nRWE;

    modport master (
        output nDEVSEL, nWE, A, Din,
        input  Dout, RegOE, RamSel, RA, nRAS, nCAS, nRWE
    );

    modport slave (
        input  nDEVSEL, nWE, A, Din,
        output Dout, RegOE, RamSel, RA, nRAS, nCAS, nRWE
    );

endinterface

// File: rtl/slinky_refresh_timer.sv
// Counts bus cycles between CAS-before-RAS refreshes; ref_due is high for the
// whole bus cycle in which a refresh must run.
module slinky_refresh_timer #(
    parameter int REF_PERIOD = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output logic ref_due
);
    localparam int CW = $clog2(REF_PERIOD);

    logic [CW-1:0] ref_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt <= '0;
        end else if (advance) begin
            ref_cnt <= (ref_cnt == CW'(REF_PERIOD - 1)) ? '0 : ref_cnt + CW'(1);
        end
    end

    assign ref_due = (ref_cnt == '0);

endmodule

// File: rtl/slinky_ram_ctrl.sv
// GR8RAM-style slot DRAM controller: auto-stepping address register, PHI-locked
// 8-state sequencer, registered DRAM strobes and CBR refresh.
module slinky_ram_ctrl
    import slinky_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int BANKS      = 2,
    parameter int REF_PERIOD = 13
) (
    input  logic             C7M,
    input  logic             nRES,
    input  logic             PHI1,
    slinky_ram_ctrl_if.slave bus,
    output logic [2:0]       dbg_state
);
    localparam int BANKS_W = $clog2(BANKS);
    localparam int RA_W    = (ADDR_W - BANKS_W) / 2;
    localparam int BANK_IW = (BANKS_W > 0) ? BANKS_W : 1;
    localparam int H_W     = ADDR_W - 16;

    seq_state_t        s;
    logic              phi1_reg;
    logic              phi0_seen;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cfg;
    logic [7:0]        bank_reg;
    logic              step_pend;
    logic              ref_due;

    logic              resync;
    logic              sel;
    logic              wsel;
    logic              data_sel;
    logic [BANK_IW-1:0] bank_idx;
    logic [RA_W-1:0]   row;
    logic [RA_W-1:0]   col;
    logic [7:0]        rd_val;
    logic [ADDR_W-1:0] addr_wr;

    assign resync   = PHI1 & ~phi1_reg & phi0_seen;
    assign sel      = ~bus.nDEVSEL & ((s == S_ROW) | (s == S_COL) | (s == S_COL2));
    assign wsel     = sel & ~bus.nWE;
    assign data_sel = sel & (bus.A == REG_DATA);
    assign bank_idx = BANK_IW'(addr >> (ADDR_W - BANKS_W));
    assign row      = RA_W'(addr >> RA_W);
    assign col      = addr[RA_W-1:0];
    assign dbg_state = s;

    slinky_refresh_timer #(.REF_PERIOD(REF_PERIOD)) u_ref (
        .clk     (C7M),
        .rst_n   (nRES),
        .advance (s == S_REF_END),
        .ref_due (ref_due)
    );

    always_comb begin
        rd_val = 8'h00;
        case (bus.A)
            REG_ADDRL: rd_val = addr[7:0];
            REG_ADDRM: rd_val = addr[15:8];
            REG_ADDRH: rd_val = 8'(addr >> 16);
            REG_CFG:   rd_val = {6'd0, cfg};
            REG_BANK:  rd_val = bank_reg;
            default:   rd_val = 8'h00;
        endcase
    end

    // A write that clears bit 7 of a byte field after it was set carries into
    // the next field up, so software can stream through pages byte-wise.
    always_comb begin
        addr_wr = addr;
        case (bus.A)
            REG_ADDRL: begin
                addr_wr[7:0] = bus.Din;
                if (addr[7] & ~bus.Din[7]) addr_wr[15:8] = addr[15:8] + 8'd1;
            end
            REG_ADDRM: begin
                addr_wr[15:8] = bus.Din;
                if (addr[15] & ~bus.Din[7])
                    addr_wr[ADDR_W-1:16] = addr[ADDR_W-1:16] + H_W'(1);
            end
            REG_ADDRH: addr_wr[ADDR_W-1:16] = H_W'(bus.Din);
            default:   addr_wr = addr;
        endcase
    end

    always_ff @(posedge C7M) begin
        phi1_reg <= PHI1;
        if (!nRES) begin
            s           <= S_IDLE;
            phi0_seen   <= 1'b0;
            addr        <= '0;
            cfg         <= CFG_RESET[1:0];
            bank_reg    <= 8'h00;
            step_pend   <= 1'b0;
            bus.nRAS    <= 1'b1;
            bus.nCAS    <= '1;
            bus.nRWE    <= 1'b1;
            bus.RegOE   <= 1'b0;
            bus.RamSel  <= 1'b0;
            bus.RA      <= '0;
            bus.Dout    <= 8'h00;
        end else begin
            if (!PHI1) phi0_seen <= 1'b1;

            if (resync) s <= S_REF_CAS;
            else if ((s != S_IDLE) && (s != S_HOLD)) s <= seq_state_t'(s + 3'd1);

            bus.nRAS   <= 1'b1;
            bus.nCAS   <= '1;
            bus.nRWE   <= 1'b1;
            bus.RamSel <= 1'b0;
            bus.RA     <= '0;
            // A resync abandons the cycle: strobes drop on this same edge.
            if (!resync) begin
                if (ref_due && ((s == S_REF_CAS) || (s == S_REF_RAS))) bus.nCAS <= '0;
                if (ref_due && ((s == S_REF_RAS) || (s == S_REF_END))) bus.nRAS <= 1'b0;
                if (data_sel) begin
                    bus.RamSel <= 1'b1;
                    bus.nRAS   <= 1'b0;
                    bus.RA     <= (s == S_ROW) ? row : col;
                    if (s != S_ROW) begin
                        bus.nCAS <= ~(BANKS'(1) << bank_idx);
                        if (!bus.nWE) bus.nRWE <= 1'b0;
                    end
                end
            end

            bus.RegOE <= ~bus.nDEVSEL & bus.nWE & s[2] & (bus.A != REG_DATA);
            bus.Dout  <= rd_val;

            if (wsel && (s == S_COL2) && !resync) begin
                case (bus.A)
                    REG_ADDRL, REG_ADDRM, REG_ADDRH: addr <= addr_wr;
                    REG_CFG:  cfg      <= bus.Din[1:0];
                    REG_BANK: bank_reg <= bus.Din;
                    default: ;
                endcase
            end

            if (data_sel && (s == S_COL2) && !resync) step_pend <= 1'b1;

            if ((s == S_HOLD) && step_pend) begin
                step_pend <= 1'b0;
                if (cfg[CFG_INCEN])
                    addr <= cfg[CFG_DEC] ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_slinky_ram_ctrl.sv
// Directed bench for slinky_ram_ctrl: per-phase strobe checks on every bus
// cycle plus register readback of hand-computed address values.
module tb_slinky_ram_ctrl;
    import slinky_pkg::*;

    localparam int ADDR_W     = 23;
    localparam int BANKS      = 2;
    localparam int REF_PERIOD = 13;
    localparam int RA_W       = 11;

    logic       clk  = 1'b0;
    logic       nres = 1'b0;
    logic       phi1 = 1'b0;
    logic [2:0] dbg_state;

    int ph      = 7;
    int n_total = 0;
    int n_bad   = 0;
    int ref_idx = 0;
    int cyc     = 0;

    logic [6:0]       o_ras, o_rwe, o_rs, o_oe;
    logic [BANKS-1:0] o_cas [1:7];
    logic [RA_W-1:0]  o_ra  [1:7];
    logic [7:0]       o_dout;

    slinky_ram_ctrl_if #(.RA_W(RA_W), .BANKS(BANKS)) bus ();

    slinky_ram_ctrl #(
        .ADDR_W     (ADDR_W),
        .BANKS      (BANKS),
        .REF_PERIOD (REF_PERIOD)
    ) dut (
        .C7M       (clk),
        .nRES      (nres),
        .PHI1      (phi1),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset / PHI: PHI1 high for phases 0..3, low for 4..7
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            ph   = (ph + 1) % 8;
            phi1 = (ph < 4);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full PHI cycle; phase p sample shows the strobes decoded from S=p.
    task automatic bus_cycle(input logic sel, input logic wr, input logic [3:0] a,
                             input logic [7:0] d, input logic [ADDR_W-1:0] ea);
        logic             dat, rf;
        logic [6:0]       e_ras, e_rwe, e_rs, e_oe;
        logic [BANKS-1:0] e_cas;
        @(posedge clk);
        while (ph != 0) @(posedge clk);
        @(negedge clk);
        bus.nDEVSEL = ~sel;
        bus.nWE     = ~wr;
        bus.A       = a;
        bus.Din     = d;
        for (int p = 1; p <= 7; p++) begin
            @(posedge clk);
            #1;
            o_ras[p-1] = bus.nRAS;
            o_rwe[p-1] = bus.nRWE;
            o_rs[p-1]  = bus.RamSel;
            o_oe[p-1]  = bus.RegOE;
            o_cas[p]   = bus.nCAS;
            o_ra[p]    = bus.RA;
            if (p == 5) o_dout = bus.Dout;
        end
        @(negedge clk);
        bus.nDEVSEL = 1'b1;
        bus.nWE     = 1'b1;

        dat = sel && (a == REG_DATA);
        rf  = (ref_idx == 0);
        for (int p = 1; p <= 7; p++) begin
            e_cas = '1;
            if (rf && p <= 2) e_cas = '0;
            if (dat && (p == 5 || p == 6)) e_cas[ea[22]] = 1'b0;
            check($sformatf("c%0d_cas_p%0d", cyc, p), 32'(o_cas[p]), 32'(e_cas));
            e_ras[p-1] = ~((rf && (p == 2 || p == 3)) || (dat && p >= 4 && p <= 6));
            e_rwe[p-1] = ~(dat && wr && (p == 5 || p == 6));
            e_rs[p-1]  = dat && p >= 4 && p <= 6;
            e_oe[p-1]  = sel && !wr && (a != REG_DATA) && p >= 4;
        end
        check($sformatf("c%0d_ras", cyc), 32'(o_ras), 32'(e_ras));
        check($sformatf("c%0d_rwe", cyc), 32'(o_rwe), 32'(e_rwe));
        check($sformatf("c%0d_ramsel", cyc), 32'(o_rs), 32'(e_rs));
        check($sformatf("c%0d_regoe", cyc), 32'(o_oe), 32'(e_oe));
        check($sformatf("c%0d_ra_row", cyc), 32'(o_ra[4]), dat ? 32'(ea[21:11]) : 32'd0);
        check($sformatf("c%0d_ra_col5", cyc), 32'(o_ra[5]), dat ? 32'(ea[10:0]) : 32'd0);
        check($sformatf("c%0d_ra_col6", cyc), 32'(o_ra[6]), dat ? 32'(ea[10:0]) : 32'd0);
        ref_idx = (ref_idx + 1) % REF_PERIOD;
        cyc++;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        bus_cycle(1'b1, 1'b1, a, d, '0);
    endtask

    task automatic rd_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus_cycle(1'b1, 1'b0, a, 8'h00, '0);
        check(tag, 32'(o_dout), 32'(exp));
    endtask

    initial begin
        bus.nDEVSEL = 1'b1;
        bus.nWE     = 1'b1;
        bus.A       = 4'h0;
        bus.Din     = 8'h00;

        repeat (20) @(posedge clk);
        #1;
        check("rst_nras", 32'(bus.nRAS), 32'd1);
        check("rst_ncas", 32'(bus.nCAS), 32'h3);
        check("rst_nrwe", 32'(bus.nRWE), 32'd1);
        check("rst_regoe", 32'(bus.RegOE), 32'd0);
        check("rst_ramsel", 32'(bus.RamSel), 32'd0);
        check("rst_ra", 32'(bus.RA), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        while (ph != 1) @(posedge clk);
        @(negedge clk);
        nres = 1'b1;

        // idle cycles: refresh on cycles 0 and 13 only
        for (int i = 0; i < 20; i++) bus_cycle(1'b0, 1'b0, 4'h0, 8'h00, '0);
        rd_reg("cfg_rst", REG_CFG, 8'h02);
        rd_reg("bank_rst", REG_BANK, 8'h00);

        // data read at 0x0012FF, increment to 0x001300
        wr_reg(REG_ADDRH, 8'h00);
        wr_reg(REG_ADDRM, 8'h12);
        wr_reg(REG_ADDRL, 8'hFF);
        bus_cycle(1'b1, 1'b0, REG_DATA, 8'h00, 23'h0012FF);
        rd_reg("inc_addrl", REG_ADDRL, 8'h00);
        rd_reg("inc_addrm", REG_ADDRM, 8'h13);
        rd_reg("inc_addrh", REG_ADDRH, 8'h00);

        // decrement from 0 wraps full width
        wr_reg(REG_CFG, 8'h03);
        wr_reg(REG_ADDRM, 8'h00);
        wr_reg(REG_ADDRL, 8'h00);
        bus_cycle(1'b1, 1'b1, REG_DATA, 8'h5A, 23'h000000);
        rd_reg("dec_addrl", REG_ADDRL, 8'hFF);
        rd_reg("dec_addrm", REG_ADDRM, 8'hFF);
        rd_reg("dec_addrh", REG_ADDRH, 8'h7F);
        rd_reg("dec_cfg", REG_CFG, 8'h03);

        // write carries
        wr_reg(REG_CFG, 8'h02);
        wr_reg(REG_ADDRL, 8'h80);
        wr_reg(REG_ADDRM, 8'h00);
        wr_reg(REG_ADDRH, 8'h00);
        rd_reg("cy_setup_m", REG_ADDRM, 8'h00);
        wr_reg(REG_ADDRL, 8'h05);
        rd_reg("cy_l_addrm", REG_ADDRM, 8'h01);
        rd_reg("cy_l_addrl", REG_ADDRL, 8'h05);
        wr_reg(REG_ADDRL, 8'h06);
        rd_reg("cy_none_m", REG_ADDRM, 8'h01);
        wr_reg(REG_ADDRM, 8'h80);
        wr_reg(REG_ADDRM, 8'h00);
        rd_reg("cy_m_addrh", REG_ADDRH, 8'h01);
        rd_reg("cy_m_addrm", REG_ADDRM, 8'h00);
        wr_reg(REG_ADDRH, 8'hFF);
        rd_reg("addrh_mask", REG_ADDRH, 8'h7F);

        // bank 1 access
        wr_reg(REG_ADDRL, 8'h00);
        wr_reg(REG_ADDRM, 8'h00);
        wr_reg(REG_ADDRH, 8'h40);
        bus_cycle(1'b1, 1'b0, REG_DATA, 8'h00, 23'h400000);
        rd_reg("b1_addrl", REG_ADDRL, 8'h01);
        rd_reg("b1_addrh", REG_ADDRH, 8'h40);

        // INCEN=0 holds the address
        wr_reg(REG_CFG, 8'h00);
        bus_cycle(1'b1, 1'b0, REG_DATA, 8'h00, 23'h400001);
        rd_reg("noinc_addrl", REG_ADDRL, 8'h01);

        rd_reg("unmapped", 4'h5, 8'h00);
        wr_reg(REG_BANK, 8'hA5);
        rd_reg("bank_rw", REG_BANK, 8'hA5);

        // reset in S5 of a data write
        @(posedge clk);
        while (ph != 0) @(posedge clk);
        @(negedge clk);
        bus.nDEVSEL = 1'b0;
        bus.nWE     = 1'b0;
        bus.A       = REG_DATA;
        bus.Din     = 8'h77;
        repeat (4) @(posedge clk);
        #1;
        check("mid_live_nras", 32'(bus.nRAS), 32'd0);
        check("mid_live_ramsel", 32'(bus.RamSel), 32'd1);
        @(negedge clk);
        nres = 1'b0;
        @(posedge clk);
        #1;
        check("mid_nras", 32'(bus.nRAS), 32'd1);
        check("mid_ncas", 32'(bus.nCAS), 32'h3);
        check("mid_nrwe", 32'(bus.nRWE), 32'd1);
        check("mid_ramsel", 32'(bus.RamSel), 32'd0);
        check("mid_ra", 32'(bus.RA), 32'd0);
        check("mid_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        nres        = 1'b1;
        bus.nDEVSEL = 1'b1;
        bus.nWE     = 1'b1;
        ref_idx     = 0;
        rd_reg("post_addrl", REG_ADDRL, 8'h00);
        rd_reg("post_addrm", REG_ADDRM, 8'h00);
        rd_reg("post_addrh", REG_ADDRH, 8'h00);
        rd_reg("post_bank", REG_BANK, 8'h00);
        rd_reg("post_cfg", REG_CFG, 8'h02);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
